psum_pipe_controller: RTL and testbench

PSUM_PIPE_CONTROLLER -- requirements
Module: psum_pipe_controller

---
 rtl/psum_pipe_controller_if.sv | 61 ++++++
 rtl/psum_pipe_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_psum_pipe_controller.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_pipe_controller_if.sv
// Handshake and strobe bundle between the psum pipeline controller and its datapath.
// The slave modport is the controller side; the master modport is the datapath/environment side.
interface psum_pipe_controller_if #(
    parameter int FILTER_ADDR_WIDTH = 8,
    parameter int CH_W              = 2
);
    logic                         start;
    logic                         if_empty;
    logic [FILTER_ADDR_WIDTH-1:0] filter_waddr;
    logic                         sp_valid;
    logic                         reading_empty;
    logic                         filter_cannot_read;
    logic                         f_co;
    logic                         go_next_stride;
    logic                         stride_ended;
    logic                         go_next_filter;
    logic                         is_last_filter;
    logic                         last_if;
    logic                         psum_valid;
    logic                         psum_wr_ack;
    logic                         error;

    logic                         chip_en;
    logic                         global_rst;
    logic                         en_p_traverse;
    logic                         ren;
    logic                         ld_if;
    logic                         mult_en;
    logic                         i_en;
    logic                         ld_result;
    logic                         en_f_counter;
    logic                         rst_f_counter;
    logic                         next_stride;
    logic                         next_filter;
    logic                         rst_stride;
    logic                         next_start;
    logic                         make_empty;
    logic                         psum_ren;
    logic                         psum_wen;
    logic                         done;
    logic                         stall_signal;
    logic [CH_W-1:0]              ch_idx;

    modport master (
        output start, if_empty, filter_waddr, sp_valid, reading_empty, filter_cannot_read,
               f_co, go_next_stride, stride_ended, go_next_filter, is_last_filter, last_if,
               psum_valid, psum_wr_ack, error,
        input  chip_en, global_rst, en_p_traverse, ren, ld_if, mult_en, i_en, ld_result,
               en_f_counter, rst_f_counter, next_stride, next_filter, rst_stride, next_start,
               make_empty, psum_ren, psum_wen, done, stall_signal, ch_idx
    );

    modport slave (
        input  start, if_empty, filter_waddr, sp_valid, reading_empty, filter_cannot_read,
               f_co, go_next_stride, stride_ended, go_next_filter, is_last_filter, last_if,
               psum_valid, psum_wr_ack, error,
        output chip_en, global_rst, en_p_traverse, ren, ld_if, mult_en, i_en, ld_result,
               en_f_counter, rst_f_counter, next_stride, next_filter, rst_stride, next_start,
               make_empty, psum_ren, psum_wen, done, stall_signal, ch_idx
    );
endinterface

// File: rtl/psum_pipe_controller.sv
// Sequencing FSM for a convolution psum pipeline: arm, fill, run, psum read/modify/write, IF advance.
// Build option PSUM_MODE_EN: when defined, partial sums are read back and accumulated over NUM_CH channels.
module psum_pipe_controller #(
    parameter int FILTER_ADDR_WIDTH = 8,
    parameter int PIPE_DEPTH        = 2,
    parameter int NUM_CH            = 4,
    parameter int CH_W              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    psum_pipe_controller_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ARM        = 4'd1,
        S_WAIT_DATA  = 4'd2,
        S_FIND_SP    = 4'd3,
        S_FILL       = 4'd4,
        S_RUN        = 4'd5,
        S_NEXT_PSUM  = 4'd6,
        S_READ_PSUM  = 4'd7,
        S_WRITE_PSUM = 4'd8,
        S_NEXT_IF    = 4'd9,
        S_UPDATE_SP  = 4'd10,
        S_DONE       = 4'd11,
        S_ERR        = 4'd12
    } state_e;

    typedef struct packed {
        logic chip_en;
        logic global_rst;
        logic en_p_traverse;
        logic ren;
        logic ld_if;
        logic mult_en;
        logic i_en;
        logic ld_result;
        logic en_f_counter;
        logic rst_f_counter;
        logic next_stride;
        logic next_filter;
        logic rst_stride;
        logic next_start;
        logic make_empty;
        logic psum_ren;
        logic psum_wen;
        logic done;
        logic stall_signal;
    } strobe_t;

    state_e    state_q, state_d, state_nxt_s;
    logic [2:0] fill_cnt_q, fill_cnt_d;
    strobe_t   out_s;
    logic      freeze_s, run_s, last_filter_s, ch_inc_s;

    assign last_filter_s = bus.is_last_filter & bus.go_next_filter;
    assign freeze_s      = bus.reading_empty | bus.filter_cannot_read | ~bus.sp_valid | last_filter_s;
    assign run_s         = ~freeze_s & ~bus.f_co;

    // Error traps every active state into ERR; IDLE ignores it.
    assign state_d = (bus.error && (state_q != S_IDLE)) ? S_ERR : state_nxt_s;

    // Per-state next-state and strobe decode.
    always_comb begin
        state_nxt_s = state_q;
        fill_cnt_d  = fill_cnt_q;
        ch_inc_s    = 1'b0;
        out_s       = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_nxt_s = S_ARM;
                else           state_nxt_s = S_IDLE;
            end
            S_ARM: begin
                out_s.chip_en    = 1'b1;
                out_s.global_rst = 1'b1;
                if (bus.start) state_nxt_s = S_ARM;
                else           state_nxt_s = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                out_s.chip_en = 1'b1;
                if (!bus.if_empty && (bus.filter_waddr != {FILTER_ADDR_WIDTH{1'b0}})) begin
                    state_nxt_s = S_FIND_SP;
                end else begin
                    state_nxt_s = S_WAIT_DATA;
                end
            end
            S_FIND_SP: begin
                out_s.chip_en       = 1'b1;
                out_s.en_p_traverse = ~bus.sp_valid;
                if (bus.sp_valid) begin
                    state_nxt_s = S_FILL;
                    fill_cnt_d  = 3'd0;
                end else begin
                    state_nxt_s = S_FIND_SP;
                end
            end
            S_FILL: begin
                out_s.chip_en = 1'b1;
                out_s.ren     = ~freeze_s;
                out_s.ld_if   = ~freeze_s;
                out_s.i_en    = ~freeze_s;
                out_s.mult_en = ~freeze_s & (fill_cnt_q != 3'd0);
                if (freeze_s) begin
                    state_nxt_s = S_FILL;
                end else if (fill_cnt_q == 3'(PIPE_DEPTH - 1)) begin
                    state_nxt_s = S_RUN;
                end else begin
                    fill_cnt_d = fill_cnt_q + 3'd1;
                end
            end
            S_RUN: begin
                out_s.chip_en      = 1'b1;
                out_s.ld_if        = run_s;
                out_s.i_en         = run_s;
                out_s.ld_result    = run_s;
                out_s.mult_en      = run_s;
                out_s.ren          = run_s;
                out_s.en_f_counter = run_s;
                out_s.next_stride  = run_s & bus.go_next_stride & ~bus.stride_ended;
                out_s.next_filter  = ~freeze_s & bus.go_next_filter;
                out_s.rst_stride   = ~freeze_s & bus.go_next_filter;
                // Last-filter advance outranks a simultaneous carry: the pending psum is dropped.
                if (last_filter_s)  state_nxt_s = S_NEXT_IF;
                else if (freeze_s)  state_nxt_s = S_RUN;
                else if (bus.f_co)  state_nxt_s = S_NEXT_PSUM;
                else                state_nxt_s = S_RUN;
            end
            S_NEXT_PSUM: begin
                out_s.chip_en       = 1'b1;
                out_s.rst_f_counter = 1'b1;
`ifdef PSUM_MODE_EN
                if (bus.ch_idx == {CH_W{1'b0}}) state_nxt_s = S_WRITE_PSUM;
                else                            state_nxt_s = S_READ_PSUM;
`else
                state_nxt_s = S_RUN;
`endif
            end
`ifdef PSUM_MODE_EN
            S_READ_PSUM: begin
                out_s.chip_en  = 1'b1;
                out_s.psum_ren = 1'b1;
                if (bus.psum_valid) state_nxt_s = S_WRITE_PSUM;
                else                state_nxt_s = S_READ_PSUM;
            end
            S_WRITE_PSUM: begin
                out_s.chip_en  = 1'b1;
                out_s.psum_wen = 1'b1;
                if (bus.psum_wr_ack) begin
                    state_nxt_s = S_RUN;
                    ch_inc_s    = 1'b1;
                end else begin
                    state_nxt_s = S_WRITE_PSUM;
                end
            end
`endif
            S_NEXT_IF: begin
                out_s.chip_en    = 1'b1;
                out_s.make_empty = 1'b1;
                out_s.rst_stride = 1'b1;
                if (bus.last_if) state_nxt_s = S_DONE;
                else             state_nxt_s = S_UPDATE_SP;
            end
            S_UPDATE_SP: begin
                out_s.chip_en    = 1'b1;
                out_s.next_start = 1'b1;
                state_nxt_s      = S_FIND_SP;
            end
            S_DONE: begin
                out_s.chip_en = 1'b1;
                out_s.done    = 1'b1;
                state_nxt_s   = S_IDLE;
            end
            S_ERR: begin
                out_s.chip_en      = 1'b1;
                out_s.stall_signal = 1'b1;
                state_nxt_s        = S_ERR;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State and fill counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fill_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

`ifdef PSUM_MODE_EN
    logic [CH_W-1:0] ch_idx_q, ch_idx_d;

    always_comb begin
        if (!ch_inc_s)                               ch_idx_d = ch_idx_q;
        else if (ch_idx_q == CH_W'(NUM_CH - 1))      ch_idx_d = {CH_W{1'b0}};
        else                                         ch_idx_d = ch_idx_q + CH_W'(1);
    end

    // Channel index advances on each acknowledged psum write.
    always_ff @(posedge clk) begin
        if (reset) ch_idx_q <= {CH_W{1'b0}};
        else       ch_idx_q <= ch_idx_d;
    end

    assign bus.ch_idx   = ch_idx_q;
    assign bus.psum_ren = out_s.psum_ren;
    assign bus.psum_wen = out_s.psum_wen;
`else
    logic unused_psum_s;
    assign unused_psum_s = bus.psum_valid ^ bus.psum_wr_ack ^ ch_inc_s ^
                           out_s.psum_ren ^ out_s.psum_wen;
    assign bus.ch_idx   = {CH_W{1'b0}};
    assign bus.psum_ren = 1'b0;
    assign bus.psum_wen = 1'b0;
`endif

    assign bus.chip_en       = out_s.chip_en;
    assign bus.global_rst    = out_s.global_rst;
    assign bus.en_p_traverse = out_s.en_p_traverse;
    assign bus.ren           = out_s.ren;
    assign bus.ld_if         = out_s.ld_if;
    assign bus.mult_en       = out_s.mult_en;
    assign bus.i_en          = out_s.i_en;
    assign bus.ld_result     = out_s.ld_result;
    assign bus.en_f_counter  = out_s.en_f_counter;
    assign bus.rst_f_counter = out_s.rst_f_counter;
    assign bus.next_stride   = out_s.next_stride;
    assign bus.next_filter   = out_s.next_filter;
    assign bus.rst_stride    = out_s.rst_stride;
    assign bus.next_start    = out_s.next_start;
    assign bus.make_empty    = out_s.make_empty;
    assign bus.done          = out_s.done;
    assign bus.stall_signal  = out_s.stall_signal;

endmodule

// File: tb/tb_psum_pipe_controller.sv
// Directed bench for psum_pipe_controller: two instances (PIPE_DEPTH 2 and 3) share one stimulus stream.
module tb_psum_pipe_controller;
    localparam int NCH = 4;

    localparam logic [18:0] M_CHIP   = 19'd1 << 18;
    localparam logic [18:0] M_GRST   = 19'd1 << 17;
    localparam logic [18:0] M_ENP    = 19'd1 << 16;
    localparam logic [18:0] M_REN    = 19'd1 << 15;
    localparam logic [18:0] M_LDIF   = 19'd1 << 14;
    localparam logic [18:0] M_MULT   = 19'd1 << 13;
    localparam logic [18:0] M_IEN    = 19'd1 << 12;
    localparam logic [18:0] M_LDRES  = 19'd1 << 11;
    localparam logic [18:0] M_ENF    = 19'd1 << 10;
    localparam logic [18:0] M_RSTF   = 19'd1 << 9;
    localparam logic [18:0] M_NSTR   = 19'd1 << 8;
    localparam logic [18:0] M_NFIL   = 19'd1 << 7;
    localparam logic [18:0] M_RSTR   = 19'd1 << 6;
    localparam logic [18:0] M_NSTART = 19'd1 << 5;
    localparam logic [18:0] M_MKE    = 19'd1 << 4;
    localparam logic [18:0] M_PREN   = 19'd1 << 3;
    localparam logic [18:0] M_PWEN   = 19'd1 << 2;
    localparam logic [18:0] M_DONE   = 19'd1 << 1;
    localparam logic [18:0] M_STALL  = 19'd1 << 0;
    localparam logic [18:0] FILL0    = M_CHIP | M_REN | M_LDIF | M_IEN;
    localparam logic [18:0] FILL1    = FILL0 | M_MULT;
    localparam logic [18:0] M_RUN    = M_CHIP | M_LDIF | M_IEN | M_LDRES | M_MULT | M_REN | M_ENF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, if_empty, sp_valid, reading_empty, filter_cannot_read, f_co;
    logic       go_next_stride, stride_ended, go_next_filter, is_last_filter, last_if;
    logic       psum_valid, psum_wr_ack, error;
    logic [7:0] filter_waddr;

    int total = 0;
    int bad   = 0;
    int ch_m  = 0;
    int sb_ch_q[$];
    bit sb_rd_q[$];

    psum_pipe_controller_if #(.FILTER_ADDR_WIDTH(8), .CH_W(2)) bus_a ();
    psum_pipe_controller_if #(.FILTER_ADDR_WIDTH(8), .CH_W(2)) bus_b ();

    psum_pipe_controller #(.FILTER_ADDR_WIDTH(8), .PIPE_DEPTH(2), .NUM_CH(NCH)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    psum_pipe_controller #(.FILTER_ADDR_WIDTH(8), .PIPE_DEPTH(3), .NUM_CH(NCH)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    assign bus_a.start = start;                   assign bus_b.start = start;
    assign bus_a.if_empty = if_empty;             assign bus_b.if_empty = if_empty;
    assign bus_a.filter_waddr = filter_waddr;     assign bus_b.filter_waddr = filter_waddr;
    assign bus_a.sp_valid = sp_valid;             assign bus_b.sp_valid = sp_valid;
    assign bus_a.reading_empty = reading_empty;   assign bus_b.reading_empty = reading_empty;
    assign bus_a.filter_cannot_read = filter_cannot_read;
    assign bus_b.filter_cannot_read = filter_cannot_read;
    assign bus_a.f_co = f_co;                     assign bus_b.f_co = f_co;
    assign bus_a.go_next_stride = go_next_stride; assign bus_b.go_next_stride = go_next_stride;
    assign bus_a.stride_ended = stride_ended;     assign bus_b.stride_ended = stride_ended;
    assign bus_a.go_next_filter = go_next_filter; assign bus_b.go_next_filter = go_next_filter;
    assign bus_a.is_last_filter = is_last_filter; assign bus_b.is_last_filter = is_last_filter;
    assign bus_a.last_if = last_if;               assign bus_b.last_if = last_if;
    assign bus_a.psum_valid = psum_valid;         assign bus_b.psum_valid = psum_valid;
    assign bus_a.psum_wr_ack = psum_wr_ack;       assign bus_b.psum_wr_ack = psum_wr_ack;
    assign bus_a.error = error;                   assign bus_b.error = error;

    wire [18:0] sa = {bus_a.chip_en, bus_a.global_rst, bus_a.en_p_traverse, bus_a.ren, bus_a.ld_if,
                      bus_a.mult_en, bus_a.i_en, bus_a.ld_result, bus_a.en_f_counter,
                      bus_a.rst_f_counter, bus_a.next_stride, bus_a.next_filter, bus_a.rst_stride,
                      bus_a.next_start, bus_a.make_empty, bus_a.psum_ren, bus_a.psum_wen,
                      bus_a.done, bus_a.stall_signal};
    wire [18:0] sb = {bus_b.chip_en, bus_b.global_rst, bus_b.en_p_traverse, bus_b.ren, bus_b.ld_if,
                      bus_b.mult_en, bus_b.i_en, bus_b.ld_result, bus_b.en_f_counter,
                      bus_b.rst_f_counter, bus_b.next_stride, bus_b.next_filter, bus_b.rst_stride,
                      bus_b.next_start, bus_b.make_empty, bus_b.psum_ren, bus_b.psum_wen,
                      bus_b.done, bus_b.stall_signal};
    wire [31:0] ch_a = {30'd0, bus_a.ch_idx};

    task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s strobes observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; f_co = 1'b0; error = 1'b0; psum_valid = 1'b0;
        psum_wr_ack = 1'b0; reading_empty = 1'b0; filter_cannot_read = 1'b0;
        go_next_filter = 1'b0; is_last_filter = 1'b0; last_if = 1'b0;
        go_next_stride = 1'b0; stride_ended = 1'b0; sp_valid = 1'b1;
        if_empty = 1'b0; filter_waddr = 8'd5;
        adv(); adv();
        reset = 1'b0; ch_m = 0;
        #1;
    endtask

    task automatic boot_a();
        start = 1'b1; #1;
        adv();
        start = 1'b0; #1;
        repeat (5) adv();
        chk("boot_run", sa, M_RUN);
    endtask

    task automatic do_psum(input int ack_dly, input int val_dly);
        int exp_ch;
        bit exp_rd;
        bit saw_rd;
        f_co = 1'b1; #1;
        chk("psum_fco", sa, M_CHIP);
`ifdef PSUM_MODE_EN
        sb_ch_q.push_back(ch_m);
        sb_rd_q.push_back(ch_m != 0);
        ch_m = (ch_m + 1) % NCH;
`else
        sb_ch_q.push_back(0);
        sb_rd_q.push_back(1'b0);
`endif
        adv();
        f_co = 1'b0; #1;
        chk("next_psum", sa, M_CHIP | M_RSTF);
        adv();
        exp_ch = sb_ch_q.pop_front();
        exp_rd = sb_rd_q.pop_front();
        saw_rd = 1'b0;
        for (int k = 0; k < 16 && bus_a.psum_ren === 1'b1; k++) begin
            saw_rd = 1'b1;
            psum_valid = (k >= val_dly); #1;
            chk("read_psum", sa, M_CHIP | M_PREN);
            chkv("read_ch", ch_a, exp_ch);
            adv();
            psum_valid = 1'b0; #1;
        end
        chkv("read_seen", {31'd0, saw_rd}, {31'd0, exp_rd});
`ifdef PSUM_MODE_EN
        for (int k = 0; k <= ack_dly; k++) begin
            psum_wr_ack = (k == ack_dly); #1;
            chk("write_psum", sa, M_CHIP | M_PWEN);
            chkv("write_ch_hold", ch_a, exp_ch);
            adv();
        end
        psum_wr_ack = 1'b0; #1;
        chk("psum_back_run", sa, M_RUN);
        chkv("ch_next", ch_a, ch_m);
`else
        chk("psum_off_run", sa, M_RUN);
        chkv("ch_zero", ch_a, exp_ch);
`endif
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; if_empty = 1'b1; filter_waddr = 8'd0; sp_valid = 1'b0;
        reading_empty = 1'b0; filter_cannot_read = 1'b0; f_co = 1'b0; go_next_stride = 1'b0;
        stride_ended = 1'b0; go_next_filter = 1'b0; is_last_filter = 1'b0; last_if = 1'b0;
        psum_valid = 1'b0; psum_wr_ack = 1'b0; error = 1'b0;
        repeat (3) adv();
        start = 1'b1; #1;
        chk("reset_idle", sa, 19'd0);
        chkv("reset_ch", ch_a, 0);
        adv();
        chk("reset_beats_start", sa, 19'd0);
        reset = 1'b0; start = 1'b0; if_empty = 1'b0; filter_waddr = 8'd5; sp_valid = 1'b1; #1;
        chk("idle", sa, 19'd0);

        // start held three cycles: ARM for three cycles, then WAIT_DATA, FIND_SP, two FILL, RUN
        start = 1'b1; #1;
        chk("idle_start", sa, 19'd0);
        adv();
        chk("arm1", sa, M_CHIP | M_GRST);
        adv();
        chk("arm2", sa, M_CHIP | M_GRST);
        adv();
        start = 1'b0; #1;
        chk("arm3", sa, M_CHIP | M_GRST);
        adv();
        filter_waddr = 8'd0; #1;
        chk("wait_waddr0", sa, M_CHIP);
        adv();
        filter_waddr = 8'd5; #1;
        chk("wait_ok", sa, M_CHIP);
        adv();
        chk("find_sp", sa, M_CHIP);
        adv();
        chk("fill0", sa, FILL0);
        adv();
        chk("fill1", sa, FILL1);
        adv();
        chk("run", sa, M_RUN);

        // RUN strobe variants, all staying in RUN
        go_next_stride = 1'b1; #1;
        chk("run_stride", sa, M_RUN | M_NSTR);
        stride_ended = 1'b1; #1;
        chk("run_stride_end", sa, M_RUN);
        go_next_stride = 1'b0; stride_ended = 1'b0; go_next_filter = 1'b1; #1;
        chk("run_nfilter", sa, M_RUN | M_NFIL | M_RSTR);
        adv();
        go_next_filter = 1'b0; reading_empty = 1'b1; f_co = 1'b1; #1;
        chk("run_freeze_fco", sa, M_CHIP);
        adv();
        reading_empty = 1'b0; f_co = 1'b0; filter_cannot_read = 1'b1; #1;
        chk("run_fcr", sa, M_CHIP);
        adv();
        filter_cannot_read = 1'b0; sp_valid = 1'b0; #1;
        chk("run_nosp", sa, M_CHIP);
        adv();
        sp_valid = 1'b1; #1;
        chk("run_resume", sa, M_RUN);

        // four psums: channel 0 write-only, channels 1..3 read-modify-write, index wraps
        do_psum(0, 0);
        do_psum(5, 0);
        do_psum(0, 2);
        do_psum(0, 0);
        chkv("ch_wrapped", ch_a, 0);

        // last filter with another IF pending: NEXT_IF, UPDATE_SP, refill
        is_last_filter = 1'b1; go_next_filter = 1'b1; last_if = 1'b0; #1;
        chk("lastf_run", sa, M_CHIP);
        adv();
        is_last_filter = 1'b0; go_next_filter = 1'b0; #1;
        chk("next_if", sa, M_CHIP | M_MKE | M_RSTR);
        adv();
        sp_valid = 1'b0; #1;
        chk("update_sp", sa, M_CHIP | M_NSTART);
        adv();
        chk("find_sp_wait", sa, M_CHIP | M_ENP);
        adv();
        chk("find_sp_wait2", sa, M_CHIP | M_ENP);
        sp_valid = 1'b1; #1;
        chk("find_sp_go", sa, M_CHIP);
        adv();
        chk("refill0", sa, FILL0);
        adv();
        chk("refill1", sa, FILL1);
        adv();
        chk("rerun", sa, M_RUN);

        // last filter, f_co and last_if together: no psum, single done, IDLE
        is_last_filter = 1'b1; go_next_filter = 1'b1; f_co = 1'b1; last_if = 1'b1; #1;
        chk("lastf_fco", sa, M_CHIP);
        adv();
        is_last_filter = 1'b0; go_next_filter = 1'b0; f_co = 1'b0; #1;
        chk("next_if_last", sa, M_CHIP | M_MKE | M_RSTR);
        adv();
        last_if = 1'b0; #1;
        chk("done", sa, M_CHIP | M_DONE);
        adv();
        chk("idle_after_done", sa, 19'd0);
        adv();
        chk("idle_stays", sa, 19'd0);
        chkv("ch_after_done", ch_a, ch_m);

        // PIPE_DEPTH=3 instance: freeze for 4 cycles mid-fill
        do_reset();
        start = 1'b1; #1;
        adv();
        start = 1'b0; #1;
        repeat (3) adv();
        chk("b_fill0", sb, FILL0);
        adv();
        reading_empty = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            chk("b_freeze", sb, M_CHIP);
            adv();
        end
        reading_empty = 1'b0; #1;
        chk("b_fill1", sb, FILL1);
        adv();
        chk("b_fill2", sb, FILL1);
        adv();
        chk("b_run", sb, M_RUN);

        // reset mid-FILL with error raised: reset wins, IDLE ignores error
        do_reset();
        start = 1'b1; #1;
        adv();
        start = 1'b0; #1;
        repeat (3) adv();
        reset = 1'b1; error = 1'b1; #1;
        chk("fill_pre_reset", sa, FILL0);
        adv();
        chk("rst_over_err", sa, 19'd0);
        reset = 1'b0; #1;
        chk("idle_err", sa, 19'd0);
        adv();
        error = 1'b0; #1;
        chk("idle_err_ignored", sa, 19'd0);

`ifdef PSUM_MODE_EN
        // reset mid-WRITE_PSUM clears a nonzero channel index
        do_reset();
        boot_a();
        do_psum(0, 0);
        f_co = 1'b1; #1;
        adv();
        f_co = 1'b0; #1;
        adv();
        psum_valid = 1'b1; #1;
        chk("rd_before_rst", sa, M_CHIP | M_PREN);
        adv();
        psum_valid = 1'b0; #1;
        chk("wr_before_rst", sa, M_CHIP | M_PWEN);
        chkv("ch_before_rst", ch_a, 1);
        reset = 1'b1; #1;
        adv();
        chk("wr_reset_idle", sa, 19'd0);
        chkv("wr_reset_ch", ch_a, 0);
        reset = 1'b0; ch_m = 0; #1;
`endif

        // error in RUN, ten stalled cycles, then reset
        do_reset();
        boot_a();
        error = 1'b1; #1;
        chk("err_in_run", sa, M_RUN);
        adv();
        error = 1'b0; #1;
        for (int k = 0; k < 10; k++) begin
            chk("stall", sa, M_CHIP | M_STALL);
            adv();
        end
        reset = 1'b1; #1;
        chk("stall_at_reset", sa, M_CHIP | M_STALL);
        adv();
        chk("err_reset_idle", sa, 19'd0);
        chkv("err_reset_ch", ch_a, 0);
        reset = 1'b0; #1;
        adv();
        chk("err_idle_stays", sa, 19'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
